// File: rtl/mem_stage_lsu_if.sv
// -----------------------------------------------------------------------------
// mem_stage_lsu_if
//   Data-memory bus between the MEM-stage LSU (initiator) and data memory.
//   Request phase : dmem_req / dmem_gnt handshake carrying we, addr, be, wdata.
//   Response phase: dmem_rvalid with dmem_rdata (stores also get an rvalid).
//
//   Signals
//     dmem_req    initiator -> memory  request valid
//     dmem_we     initiator -> memory  1 = write
//     dmem_addr   initiator -> memory  word-aligned byte address
//     dmem_be     initiator -> memory  byte enables
//     dmem_wdata  initiator -> memory  lane-replicated write data
//     dmem_gnt    memory -> initiator  request accepted
//     dmem_rvalid memory -> initiator  response valid
//     dmem_rdata  memory -> initiator  read data
//
//   Modports: master = LSU side, slave = memory side.
// -----------------------------------------------------------------------------
interface mem_stage_lsu_if #(
  parameter int XLEN = 32
);
  logic            dmem_req;
  logic            dmem_we;
  logic [XLEN-1:0] dmem_addr;
  logic [3:0]      dmem_be;
  logic [XLEN-1:0] dmem_wdata;
  logic            dmem_gnt;
  logic            dmem_rvalid;
  logic [XLEN-1:0] dmem_rdata;

  modport master (
    output dmem_req, dmem_we, dmem_addr, dmem_be, dmem_wdata,
    input  dmem_gnt, dmem_rvalid, dmem_rdata
  );

  modport slave (
    input  dmem_req, dmem_we, dmem_addr, dmem_be, dmem_wdata,
    output dmem_gnt, dmem_rvalid, dmem_rdata
  );
endinterface

// File: rtl/mem_stage_lsu.sv
// -----------------------------------------------------------------------------
// mem_stage_lsu
//   MEM-stage load/store unit. Takes the EX/MEM register outputs, issues one
//   data-memory access at a time over mem_stage_lsu_if and freezes the
//   pipeline (stall_M) until the access has completed.
//
//   Sequence per access: IDLE (capture) -> REQ (req until gnt) ->
//   WAIT (until rvalid) -> DONE (stall released, pipeline advances) -> IDLE.
//   Non-memory instructions pass through IDLE with no stall.
//
//   Ports
//     clk, reset      clock, synchronous active-high reset
//     ALUResult_M     effective byte address
//     writeData_M     store source (rs2)
//     instruction_M   MEM-stage instruction, funct3 in [14:12]
//     memWrite_M      store (wins over resultSrc_M)
//     resultSrc_M     2'b01 = load
//     readData_M      formatted load result, registered, updated only by loads
//     stall_M         pipeline freeze request
//     misalign_M      one-cycle misaligned-access pulse (trap build only)
//     dmem            data-memory bus, master side
//
//   Build option
//     LSU_MISALIGN_TRAP_EN  when defined, misaligned half/word accesses are
//                           not issued; they finish in DONE with misalign_M=1
//                           and a zero load result. When undefined, misalign_M
//                           is constant 0 and low address bits are truncated
//                           by the lane formatting.
// -----------------------------------------------------------------------------
module mem_stage_lsu #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [XLEN-1:0] ALUResult_M,
  input  logic [XLEN-1:0] writeData_M,
  input  logic [XLEN-1:0] instruction_M,
  input  logic            memWrite_M,
  input  logic [1:0]      resultSrc_M,
  output logic [XLEN-1:0] readData_M,
  output logic            stall_M,
  output logic            misalign_M,
  mem_stage_lsu_if.master dmem
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_REQ  = 2'd1;
  localparam logic [1:0] S_WAIT = 2'd2;
  localparam logic [1:0] S_DONE = 2'd3;

  logic [1:0]  state_q,    state_d;
  logic        we_q,       we_d;
  logic [31:0] addr_q,     addr_d;
  logic [3:0]  be_q,       be_d;
  logic [31:0] wdata_q,    wdata_d;
  logic [2:0]  funct3_q,   funct3_d;
  logic [1:0]  lsb_q,      lsb_d;
  logic [31:0] rdata_q,    rdata_d;
  logic        misalign_q, misalign_d;

  logic        access;
  logic        is_store;
  logic [2:0]  funct3;
  logic [1:0]  lane;
  logic        misaligned;
  logic        trap;
  logic [3:0]  store_be;
  logic [31:0] store_wdata;
  logic [7:0]  ld_byte;
  logic [15:0] ld_half;
  logic [31:0] load_fmt;

  // Only funct3 is decoded from the instruction word.
  logic        unused_instr;
  assign unused_instr = ^{instruction_M[31:15], instruction_M[11:0]};

  assign is_store = memWrite_M;
  assign access   = memWrite_M | (resultSrc_M == 2'b01);
  assign funct3   = instruction_M[14:12];
  assign lane     = ALUResult_M[1:0];

`ifdef LSU_MISALIGN_TRAP_EN
  // funct3[1:0]: 00 byte, 01 half, 1x word (011/110/111 behave as word).
  assign misaligned = (funct3[1:0] == 2'b01) ? lane[0]
                    : (funct3[1]           ? (lane != 2'b00) : 1'b0);
`else
  assign misaligned = 1'b0;
`endif
  assign trap = access & misaligned;

  // Store lane formatting: data is replicated so any enabled lane sees it.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path leaves
    // it unassigned, which would otherwise infer a latch.
    store_be    = 4'b1111;
    store_wdata = writeData_M;
    case (funct3[1:0])
      2'b00: begin
        store_be    = 4'b0001 << lane;
        store_wdata = {4{writeData_M[7:0]}};
      end
      2'b01: begin
        store_be    = lane[1] ? 4'b1100 : 4'b0011;
        store_wdata = {2{writeData_M[15:0]}};
      end
      default: ;
    endcase
  end

  // Load alignment uses the address bits captured at issue time.
  always_comb begin
    ld_byte = dmem.dmem_rdata[7:0];
    case (lsb_q)
      2'd1:    ld_byte = dmem.dmem_rdata[15:8];
      2'd2:    ld_byte = dmem.dmem_rdata[23:16];
      2'd3:    ld_byte = dmem.dmem_rdata[31:24];
      default: ;
    endcase
    ld_half = lsb_q[1] ? dmem.dmem_rdata[31:16] : dmem.dmem_rdata[15:0];
    case (funct3_q)
      3'b000:  load_fmt = {{24{ld_byte[7]}}, ld_byte};
      3'b100:  load_fmt = {24'h0, ld_byte};
      3'b001:  load_fmt = {{16{ld_half[15]}}, ld_half};
      3'b101:  load_fmt = {16'h0, ld_half};
      default: load_fmt = dmem.dmem_rdata;
    endcase
  end

  always_comb begin
    state_d    = state_q;
    we_d       = we_q;
    addr_d     = addr_q;
    be_d       = be_q;
    wdata_d    = wdata_q;
    funct3_d   = funct3_q;
    lsb_d      = lsb_q;
    rdata_d    = rdata_q;
    misalign_d = 1'b0;
    stall_M    = 1'b0;

    case (state_q)
      S_IDLE: begin
        stall_M = access;
        if (trap) begin
          // Misaligned access never reaches the bus.
          state_d    = S_DONE;
          misalign_d = 1'b1;
          if (!is_store) rdata_d = '0;
        end else if (access) begin
          state_d  = S_REQ;
          we_d     = is_store;
          addr_d   = {ALUResult_M[31:2], 2'b00};
          be_d     = is_store ? store_be : 4'b1111;
          wdata_d  = store_wdata;
          funct3_d = funct3;
          lsb_d    = lane;
        end
      end
      S_REQ: begin
        stall_M = 1'b1;
        if (dmem.dmem_gnt) state_d = S_WAIT;
      end
      S_WAIT: begin
        stall_M = 1'b1;
        if (dmem.dmem_rvalid) begin
          state_d = S_DONE;
          // Store responses carry no data worth keeping.
          if (!we_q) rdata_d = load_fmt;
        end
      end
      default: begin
        // DONE: stall drops so the pipeline advances on this edge.
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples pre-edge values regardless of statement order.
    if (reset) begin
      // NOTE: the bus output registers are reset too, so the memory never
      // sees stale address/enable/data values after a mid-access reset.
      state_q    <= S_IDLE;
      we_q       <= 1'b0;
      addr_q     <= '0;
      be_q       <= '0;
      wdata_q    <= '0;
      funct3_q   <= '0;
      lsb_q      <= '0;
      rdata_q    <= '0;
      misalign_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      we_q       <= we_d;
      addr_q     <= addr_d;
      be_q       <= be_d;
      wdata_q    <= wdata_d;
      funct3_q   <= funct3_d;
      lsb_q      <= lsb_d;
      rdata_q    <= rdata_d;
      misalign_q <= misalign_d;
    end
  end

  assign dmem.dmem_req   = (state_q == S_REQ);
  assign dmem.dmem_we    = we_q;
  assign dmem.dmem_addr  = addr_q;
  assign dmem.dmem_be    = be_q;
  assign dmem.dmem_wdata = wdata_q;
  assign readData_M      = rdata_q;
  assign misalign_M      = misalign_q;

endmodule
